dx_hazard_ctrl: RTL
===================

Name: dx_hazard_ctrl

Overview:
- Generates the per-cycle write-enable and flush controls for the PC register, the FD latch and the DX latch of the 2-wide pipeline.
- It is the driving end of the latch control interface: the latches are written through their writeEnable inputs and bubbled through their reset inputs.
- Sits beside decode and detects the following, then sequences stalls, split issue and redirects:
  - load-use hazards against the DX stage;
  - intra-pair dependences;
  - multi-cycle mult/div occupancy;
  - branch mispredicts.

Parameters:
REG_BITS, 5, register specifier width
MD_MAX_CYCLES, 40, mult/div watchdog limit in cycles
CNT_BITS, 6, width of the mult/div cycle counter (must hold MD_MAX_CYCLES)

Ports:
clock  in  1  rising-edge clock
ctrl_reset  in  1  asynchronous, active-low reset
d_valid0, d_valid1  in  1 each  slot 0/1 valid in decode
d_rs0, d_rt0, d_rs1, d_rt1  in  REG_BITS each  decode source specifiers
d_use_rt0, d_use_rt1  in  1 each  slot reads rt
d_rd0  in  REG_BITS  slot 0 destination
d_wr0  in  1  slot 0 writes register file
x_load0, x_load1  in  1 each  DX slot 0/1 holds a valid load
x_rd0, x_rd1  in  REG_BITS each  DX slot destinations
x_md_start  in  1  mult/div entering execute this cycle
md_ready  in  1  mult/div result ready
x_mispredict  in  1  execute resolved a mispredicted branch
pc_we  out  1  PC write enable
fd_we  out  1  FD latch write enable
fd_flush  out  1  FD latch bubble
dx_we  out  1  DX latch write enable
dx_flush  out  1  DX latch bubble
issue_mask  out  2  bit0: slot 0 enters DX; bit1: slot 1 enters DX
stall_cause  out  2  00 none, 01 load-use, 10 pair split, 11 mult/div
md_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- States: RUN, SPLIT, MD_WAIT, REDIRECT. State and counter are registered; outputs are combinational from state and inputs.
- Reset (ctrl_reset=0, asynchronous):
  - state=RUN, counter=0.
  - Outputs forced: pc_we=0, fd_we=0, dx_we=0, fd_flush=1, dx_flush=1, issue_mask=00, stall_cause=00, md_timeout=0.
- Register 0 never creates a hazard.
- LU(slot) is true when a valid D slot has rs, or rt with use_rt=1, nonzero and equal to x_rdN of a DX slot whose x_loadN=1.
- PAIR is true when all of the following hold: d_valid0, d_valid1, d_wr0, d_rd0!=0, and (d_rs1==d_rd0, or d_use_rt1 with d_rt1==d_rd0).
- Default (no hazard): pc_we=fd_we=dx_we=1, flushes 0, issue_mask={d_valid1,d_valid0}, stall_cause=00.
- Priority in every state: x_mispredict > MD_WAIT hold > load-use > PAIR.
- x_mispredict (any state):
  - pc_we=1, fd_flush=1, dx_flush=1, issue_mask=00.
  - Next state REDIRECT, counter cleared.
  - Overrides MD_WAIT and SPLIT; the split slot 1 is discarded.
- REDIRECT: one cycle of pc_we=1, fd_we=1, fd_flush=1, dx_we=1, dx_flush=1, issue_mask=00 → RUN. A new mispredict here re-enters REDIRECT.
- RUN, in priority order:
  - x_md_start: default outputs this cycle → MD_WAIT, counter=1.
  - Else LU(0) or LU(1): pc_we=0, fd_we=0, dx_flush=1, issue_mask=00, stall_cause=01, stay RUN. The hazard re-evaluates next cycle, so exactly one bubble per load.
  - Else PAIR: pc_we=0, fd_we=0, dx_we=1, issue_mask=01, stall_cause=10 → SPLIT.
- SPLIT:
  - LU(1), which includes slot 1 depending on slot 0 when slot 0 is a load: pc_we=0, fd_we=0, dx_flush=1, issue_mask=00, stall_cause=01, stay SPLIT.
  - Otherwise: pc_we=1, fd_we=1, dx_we=1, issue_mask=10 → RUN.
- MD_WAIT:
  - While waiting: pc_we=fd_we=dx_we=0, dx_flush=0, stall_cause=11, counter increments (saturates at MD_MAX_CYCLES).
  - md_ready=1: the same cycle is still stalled → RUN, counter=0.
  - Counter==MD_MAX_CYCLES with md_ready=0: md_timeout=1 for that cycle → RUN, counter=0.
  - md_ready and watchdog expiry in the same cycle: md_ready wins, md_timeout=0.
- Reset asserted mid-SPLIT or mid-MD_WAIT aborts immediately to RUN with the reset outputs above.

Test Plan:
- Reset low 3 cycles then release → pc_we/fd_we/dx_we 0 and both flushes 1 during reset; default outputs (we=1, flushes 0) on the first cycle after release.
- x_load0=1, x_rd0=7, d_valid0=1, d_rs0=7 → one cycle with pc_we=0, dx_flush=1, stall_cause=01; next cycle x_load0=0 → issue_mask=11. Repeat with x_rd0=0, d_rs0=0 → no stall.
- d_wr0=1, d_rd0=5, d_use_rt1=1, d_rt1=5 → cycle 1 issue_mask=01, pc_we=0, stall_cause=10; cycle 2 issue_mask=10, pc_we=1.
- x_md_start then md_ready after 10 cycles → 10 cycles with stall_cause=11 and all we=0, RUN on the 11th cycle. Separately, md_ready held 0 → md_timeout pulses exactly once at cycle 40.
- x_mispredict during SPLIT and during MD_WAIT → same cycle fd_flush=dx_flush=1, pc_we=1; next cycle REDIRECT bubble; then RUN; no slot-1 issue.
- x_mispredict coincident with a load-use condition → flush outputs win, stall_cause=00.

Source files
------------

// File: rtl/dx_hazard_ctrl_if.sv
// Latch-control bundle between decode/execute status and the PC/FD/DX latch controls.
// The master end (the hazard controller) drives the latch enables and bubbles.
interface dx_hazard_ctrl_if #(
  parameter int unsigned REG_BITS = 5
);
  logic                d_valid0, d_valid1;
  logic [REG_BITS-1:0] d_rs0, d_rt0, d_rs1, d_rt1;
  logic                d_use_rt0, d_use_rt1;
  logic [REG_BITS-1:0] d_rd0;
  logic                d_wr0;
  logic                x_load0, x_load1;
  logic [REG_BITS-1:0] x_rd0, x_rd1;
  logic                x_md_start;
  logic                md_ready;
  logic                x_mispredict;

  logic                pc_we;
  logic                fd_we;
  logic                fd_flush;
  logic                dx_we;
  logic                dx_flush;
  logic [1:0]          issue_mask;
  logic [1:0]          stall_cause;
  logic                md_timeout;

  modport master (
    input  d_valid0, d_valid1, d_rs0, d_rt0, d_rs1, d_rt1, d_use_rt0, d_use_rt1,
           d_rd0, d_wr0, x_load0, x_load1, x_rd0, x_rd1, x_md_start, md_ready,
           x_mispredict,
    output pc_we, fd_we, fd_flush, dx_we, dx_flush, issue_mask, stall_cause, md_timeout
  );

  modport slave (
    output d_valid0, d_valid1, d_rs0, d_rt0, d_rs1, d_rt1, d_use_rt0, d_use_rt1,
           d_rd0, d_wr0, x_load0, x_load1, x_rd0, x_rd1, x_md_start, md_ready,
           x_mispredict,
    input  pc_we, fd_we, fd_flush, dx_we, dx_flush, issue_mask, stall_cause, md_timeout
  );
endinterface

// File: rtl/dx_hazard_ctrl.sv
// Hazard controller for the 2-wide pipeline: load-use stalls, pair splitting,
// mult/div occupancy with watchdog, and mispredict redirects.
module dx_hazard_ctrl #(
  parameter int unsigned REG_BITS      = 5,
  parameter int unsigned MD_MAX_CYCLES = 40,
  parameter int unsigned CNT_BITS      = 6
) (
  input logic             clock,
  input logic             ctrl_reset,
  dx_hazard_ctrl_if.master hz
);

  typedef enum logic [1:0] {RUN, SPLIT, MD_WAIT, REDIRECT} state_t;

  state_t              state, state_nx;
  logic [CNT_BITS-1:0] cnt, cnt_nx;
  logic                lu0, lu1, pair, md_expired;

  // A source hits when it is nonzero and names the destination of a load in DX.
  function automatic logic load_hit(input logic [REG_BITS-1:0] src,
                                    input logic x_load0, input logic [REG_BITS-1:0] x_rd0,
                                    input logic x_load1, input logic [REG_BITS-1:0] x_rd1);
    return (src != '0) && ((x_load0 && (src == x_rd0)) || (x_load1 && (src == x_rd1)));
  endfunction

  always_comb begin
    lu0 = hz.d_valid0 &&
          (load_hit(hz.d_rs0, hz.x_load0, hz.x_rd0, hz.x_load1, hz.x_rd1) ||
           (hz.d_use_rt0 && load_hit(hz.d_rt0, hz.x_load0, hz.x_rd0, hz.x_load1, hz.x_rd1)));
    lu1 = hz.d_valid1 &&
          (load_hit(hz.d_rs1, hz.x_load0, hz.x_rd0, hz.x_load1, hz.x_rd1) ||
           (hz.d_use_rt1 && load_hit(hz.d_rt1, hz.x_load0, hz.x_rd0, hz.x_load1, hz.x_rd1)));
    pair = hz.d_valid0 && hz.d_valid1 && hz.d_wr0 && (hz.d_rd0 != '0) &&
           ((hz.d_rs1 == hz.d_rd0) || (hz.d_use_rt1 && (hz.d_rt1 == hz.d_rd0)));
    md_expired = (cnt == CNT_BITS'(MD_MAX_CYCLES));
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    hz.pc_we       = 1'b1;
    hz.fd_we       = 1'b1;
    hz.fd_flush    = 1'b0;
    hz.dx_we       = 1'b1;
    hz.dx_flush    = 1'b0;
    hz.issue_mask  = {hz.d_valid1, hz.d_valid0};
    hz.stall_cause = 2'b00;
    hz.md_timeout  = 1'b0;

    // Reset also gates the outputs so the latches see bubbles while it is held.
    if (!ctrl_reset) begin
      hz.pc_we      = 1'b0;
      hz.fd_we      = 1'b0;
      hz.dx_we      = 1'b0;
      hz.fd_flush   = 1'b1;
      hz.dx_flush   = 1'b1;
      hz.issue_mask = 2'b00;
      state_nx      = RUN;
      cnt_nx        = '0;
    end else if (hz.x_mispredict || (state == REDIRECT)) begin
      hz.fd_flush   = 1'b1;
      hz.dx_flush   = 1'b1;
      hz.issue_mask = 2'b00;
      state_nx      = hz.x_mispredict ? REDIRECT : RUN;
      cnt_nx        = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (hz.x_md_start) begin
            state_nx = MD_WAIT;
            cnt_nx   = CNT_BITS'(1);
          end else if (lu0 || lu1) begin
            hz.pc_we       = 1'b0;
            hz.fd_we       = 1'b0;
            hz.dx_flush    = 1'b1;
            hz.issue_mask  = 2'b00;
            hz.stall_cause = 2'b01;
          end else if (pair) begin
            hz.pc_we       = 1'b0;
            hz.fd_we       = 1'b0;
            hz.issue_mask  = 2'b01;
            hz.stall_cause = 2'b10;
            state_nx       = SPLIT;
          end
        end
        SPLIT: begin
          if (lu1) begin
            hz.pc_we       = 1'b0;
            hz.fd_we       = 1'b0;
            hz.dx_flush    = 1'b1;
            hz.issue_mask  = 2'b00;
            hz.stall_cause = 2'b01;
          end else begin
            hz.issue_mask = 2'b10;
            state_nx      = RUN;
          end
        end
        MD_WAIT: begin
          hz.pc_we       = 1'b0;
          hz.fd_we       = 1'b0;
          hz.dx_we       = 1'b0;
          hz.issue_mask  = 2'b00;
          hz.stall_cause = 2'b11;
          if (hz.md_ready) begin
            state_nx = RUN;
            cnt_nx   = '0;
          end else if (md_expired) begin
            hz.md_timeout = 1'b1;
            state_nx      = RUN;
            cnt_nx        = '0;
          end else begin
            cnt_nx = cnt + CNT_BITS'(1);
          end
        end
        default: begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

endmodule
